// File: rtl/mem_common.sv
// Shared types for the fetch / fill-buffer / memory interfaces.
package mem_common;

  localparam int unsigned PADDR_W    = 32;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned FE_ID_W    = 4;
  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned LINE_WORDS = LINE_BYTES / 4;
  localparam int unsigned LINE_OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned WORD_IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W      = PADDR_W - LINE_OFF_W;

  typedef logic [PADDR_W-1:0]                   t_paddr;
  typedef logic [TAG_W-1:0]                     t_fb_tag;
  typedef logic [LINE_WORDS-1:0][INSTR_W-1:0]   t_fb_line;

  typedef struct packed {
    logic               valid;
    t_paddr             addr;
    logic [FE_ID_W-1:0] id;
  } t_fe_fb_req;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    t_paddr             pc;
  } t_fb_fe_rsp;

  typedef struct packed {
    logic   valid;
    t_paddr addr;
  } t_fb_mem_req;

  typedef struct packed {
    logic     valid;
    t_fb_line data;
  } t_mem_fb_rsp;

  typedef enum logic [1:0] {
    FB_IDLE,
    FB_MISS_REQ,
    FB_MISS_WAIT,
    FB_RSP
  } t_fsm_fb;

endpackage

// File: rtl/fe_fill_buf_tags.sv
// Tag CAM for the fill buffer: valid bits, hit lookup, victim selection
// and bulk invalidate.
module fe_fill_buf_tags
  import mem_common::*;
#(
  parameter int unsigned N_LINES = 4,
  localparam int unsigned IDX_W  = $clog2(N_LINES)
) (
  input  logic             clk,
  input  logic             reset,
  input  t_fb_tag          lookup_tag_i,
  input  logic             fill_i,
  input  t_fb_tag          fill_tag_i,
  input  logic             inv_all_i,
  output logic             hit_c_o,
  output logic [IDX_W-1:0] hit_idx_c_o,
  output logic [IDX_W-1:0] victim_c_o
);

  logic [N_LINES-1:0] valid_q, valid_d;
  logic [IDX_W-1:0]   repl_ptr_q, repl_ptr_d;
  t_fb_tag            tag_q [N_LINES];
  logic [N_LINES-1:0] hit_vec_c;
  logic               install_c;
  logic               found_c;

  // Parallel compare; the index encoder relies on at most one match.
  always_comb begin
    hit_vec_c   = '0;
    hit_idx_c_o = '0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      hit_vec_c[i] = valid_q[i] && (tag_q[i] == lookup_tag_i);
      if (hit_vec_c[i]) hit_idx_c_o = IDX_W'(i);
    end
    hit_c_o = |hit_vec_c;
  end

  // Lowest invalid entry wins, otherwise the round-robin pointer.
  always_comb begin
    victim_c_o = repl_ptr_q;
    found_c    = 1'b0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      if (!valid_q[i] && !found_c) begin
        victim_c_o = IDX_W'(i);
        found_c    = 1'b1;
      end
    end
  end

  assign install_c = fill_i && !inv_all_i;

  always_comb begin
    valid_d    = valid_q;
    repl_ptr_d = repl_ptr_q;
    if (install_c) begin
      valid_d[victim_c_o] = 1'b1;
      repl_ptr_d          = repl_ptr_q + IDX_W'(1);
    end
    if (inv_all_i) valid_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      repl_ptr_q <= '0;
    end else begin
      valid_q    <= valid_d;
      repl_ptr_q <= repl_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (install_c) tag_q[victim_c_o] <= fill_tag_i;
  end

  a_one_hit: assert property (@(posedge clk) disable iff (!reset) $onehot0(hit_vec_c));

endmodule

// File: rtl/fe_fill_buf.sv
// Fetch-side fill buffer: single-outstanding instruction lookup in a small
// fully-associative line store, with line fills from memory on a miss.
module fe_fill_buf
  import mem_common::*;
#(
  parameter int unsigned N_LINES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  t_fe_fb_req fe_fb_req_nnn,
  output t_fb_fe_rsp fb_fe_rsp_nnn,
  input  logic       flush_nnn,
  input  logic       inv_all_nnn,
  output logic       fb_mem_req_valid,
  output t_paddr     fb_mem_req_addr,
  input  logic       mem_fb_req_rdy,
  input  logic       mem_fb_rsp_valid,
  input  t_fb_line   mem_fb_rsp_data
);

  localparam int unsigned IDX_W = $clog2(N_LINES);

  t_fsm_fb            state_q, state_d;
  t_paddr             addr_q, addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               drop_q, drop_d;
  t_fb_line           data_q [N_LINES];

  logic               hit_c;
  logic [IDX_W-1:0]   hit_idx_c, victim_c;
  logic               req_ok_c, fill_c, install_c;
  logic               unused_c;

  fe_fill_buf_tags #(.N_LINES(N_LINES)) u_tags (
    .clk          (clk),
    .reset        (reset),
    .lookup_tag_i (fe_fb_req_nnn.addr[PADDR_W-1:LINE_OFF_W]),
    .fill_i       (fill_c),
    .fill_tag_i   (addr_q[PADDR_W-1:LINE_OFF_W]),
    .inv_all_i    (inv_all_nnn),
    .hit_c_o      (hit_c),
    .hit_idx_c_o  (hit_idx_c),
    .victim_c_o   (victim_c)
  );

  assign req_ok_c  = fe_fb_req_nnn.valid && !flush_nnn &&
                     (state_q == FB_IDLE || state_q == FB_RSP);
  assign fill_c    = (state_q == FB_MISS_WAIT) && mem_fb_rsp_valid;
  assign install_c = fill_c && !inv_all_nnn;
  assign unused_c  = ^{fe_fb_req_nnn.id, fe_fb_req_nnn.addr[1:0]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    drop_d  = drop_q;
    unique case (state_q)
      FB_IDLE, FB_RSP: begin
        state_d = FB_IDLE;
        if (req_ok_c) begin
          addr_d = fe_fb_req_nnn.addr;
          if (hit_c) begin
            instr_d = data_q[hit_idx_c][fe_fb_req_nnn.addr[LINE_OFF_W-1:2]];
            state_d = FB_RSP;
          end else begin
            state_d = FB_MISS_REQ;
          end
        end
      end
      FB_MISS_REQ: begin
        // Once memory has taken the request the fill must still be absorbed.
        if (mem_fb_req_rdy) begin
          state_d = FB_MISS_WAIT;
          drop_d  = flush_nnn;
        end else if (flush_nnn) begin
          state_d = FB_IDLE;
        end
      end
      FB_MISS_WAIT: begin
        if (flush_nnn) drop_d = 1'b1;
        if (mem_fb_rsp_valid) begin
          drop_d  = 1'b0;
          instr_d = mem_fb_rsp_data[addr_q[LINE_OFF_W-1:2]];
          state_d = (drop_q || flush_nnn) ? FB_IDLE : FB_RSP;
        end
      end
      default: state_d = FB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FB_IDLE;
      addr_q  <= '0;
      instr_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (install_c) data_q[victim_c] <= mem_fb_rsp_data;
  end

  always_comb begin
    fb_fe_rsp_nnn.valid = (state_q == FB_RSP) && !flush_nnn;
    fb_fe_rsp_nnn.instr = instr_q;
    fb_fe_rsp_nnn.pc    = addr_q;
  end

  assign fb_mem_req_valid = (state_q == FB_MISS_REQ);
  assign fb_mem_req_addr  = {addr_q[PADDR_W-1:LINE_OFF_W], LINE_OFF_W'(0)};

  a_req_state: assert property (@(posedge clk) disable iff (!reset)
    fe_fb_req_nnn.valid |-> (state_q == FB_IDLE || state_q == FB_RSP));
  a_req_align: assert property (@(posedge clk) disable iff (!reset)
    fe_fb_req_nnn.valid |-> (fe_fb_req_nnn.addr[1:0] == 2'b00));
  a_fill_state: assert property (@(posedge clk) disable iff (!reset)
    mem_fb_rsp_valid |-> (state_q == FB_MISS_WAIT));

endmodule
